// File: rtl/fila_escrita_registradores_pkg.sv
// Shared MIPS register-file definitions used by the write-back queue.
package fila_escrita_registradores_pkg;

    localparam int REG_ADDR_W = 32'd5;
    localparam int DATA_W     = 32'd32;
    localparam int NUM_REGS   = 32'd32;
    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

    // True when the register number is the hard-wired $zero register.
    function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] reg_num);
        return (reg_num == REG_ZERO);
    endfunction

endpackage

// File: rtl/fila_escrita_registradores_busca_encaminhamento.sv
// Forwarding lookup: finds the youngest valid pending write that targets a
// given register. Entries are walked oldest to youngest so a later match
// overrides an earlier one.
module busca_encaminhamento
    import fila_escrita_registradores_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic [PW-1:0]                         head_i,
    input  logic [CW-1:0]                         count_i,
    input  logic [DEPTH-1:0][REG_ADDR_W-1:0]      regs_i,
    input  logic [DEPTH-1:0][DATA_W-1:0]          data_i,
    input  logic [REG_ADDR_W-1:0]                 num_reg_i,
    output logic                                  hit_o,
    output logic [DATA_W-1:0]                     data_o
);

    // match_s[k]: the k-th oldest entry is valid and targets num_reg_i
    logic [DEPTH-1:0]              match_s;
    logic [DEPTH-1:0][DATA_W-1:0]  age_data_s;

    // Reorder entries by age and flag the valid ones that match.
    always_comb begin
        match_s    = {DEPTH{1'b0}};
        age_data_s = {(DEPTH*DATA_W){1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            match_s[k]    = (CW'(k) < count_i) &&
                            (regs_i[head_i + PW'(k)] == num_reg_i);
            age_data_s[k] = data_i[head_i + PW'(k)];
        end
    end

    // Priority pick: the youngest matching entry wins, zero when nothing hits.
    always_comb begin
        hit_o  = 1'b0;
        data_o = {DATA_W{1'b0}};
        for (int k = 0; k < DEPTH; k++) begin
            hit_o  = hit_o | match_s[k];
            data_o = match_s[k] ? age_data_s[k] : data_o;
        end
    end

endmodule

// File: rtl/fila_escrita_registradores.sv
// Write-back queue in front of the single write port of the 32x32 MIPS
// register file, with forwarding lookups for both read ports.
module fila_escrita_registradores
    import fila_escrita_registradores_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter bit ZERO_REG_RO = 1'b0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [REG_ADDR_W-1:0]         in_reg,
    input  logic [DATA_W-1:0]             in_data,
    input  logic                          wb_hold,
    output logic                          RegWrite,
    output logic [REG_ADDR_W-1:0]         Numero_Reg_Escrita,
    output logic [DATA_W-1:0]             Dado_escrita,
    input  logic [REG_ADDR_W-1:0]         Numero_Reg1,
    input  logic [REG_ADDR_W-1:0]         Numero_Reg2,
    output logic                          fwd_hit1,
    output logic                          fwd_hit2,
    output logic [DATA_W-1:0]             fwd_data1,
    output logic [DATA_W-1:0]             fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]    pending_count,
    output logic                          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    // Entry storage is only meaningful below count_q, so it carries no reset.
    logic [DEPTH-1:0][REG_ADDR_W-1:0] regs_q;
    logic [DEPTH-1:0][DATA_W-1:0]     data_q;

    logic full_s;
    logic empty_s;
    logic store_s;
    logic pop_s;

    // Handshake, retire decision and next-state pointer/count arithmetic.
    always_comb begin
        full_s  = (count_q == CW'(DEPTH));
        empty_s = (count_q == {CW{1'b0}});
        // A full queue refuses new work even if it retires this cycle.
        in_ready = !full_s;
        pop_s    = !empty_s && !wb_hold;
        // Writes to $zero complete the handshake but are not stored when read-only.
        store_s  = in_valid && !full_s && !(ZERO_REG_RO && is_zero_reg(in_reg));

        head_d = pop_s   ? (head_q + PW'(1)) : head_q;
        tail_d = store_s ? (tail_q + PW'(1)) : tail_q;
        case ({store_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Register-file write port always presents the head entry, zero when empty.
    always_comb begin
        RegWrite      = pop_s;
        empty         = empty_s;
        pending_count = count_q;
        if (empty_s) begin
            Numero_Reg_Escrita = {REG_ADDR_W{1'b0}};
            Dado_escrita       = {DATA_W{1'b0}};
        end else begin
            Numero_Reg_Escrita = regs_q[head_q];
            Dado_escrita       = data_q[head_q];
        end
    end

    // Pointer and occupancy registers; reset discards every pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= {PW{1'b0}};
            tail_q  <= {PW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: capture the accepted request at the tail slot.
    always_ff @(posedge clk) begin
        if (store_s) begin
            regs_q[tail_q] <= in_reg;
            data_q[tail_q] <= in_data;
        end
    end

    busca_encaminhamento #(.DEPTH(DEPTH)) u_busca1 (
        .head_i    (head_q),
        .count_i   (count_q),
        .regs_i    (regs_q),
        .data_i    (data_q),
        .num_reg_i (Numero_Reg1),
        .hit_o     (fwd_hit1),
        .data_o    (fwd_data1)
    );

    busca_encaminhamento #(.DEPTH(DEPTH)) u_busca2 (
        .head_i    (head_q),
        .count_i   (count_q),
        .regs_i    (regs_q),
        .data_i    (data_q),
        .num_reg_i (Numero_Reg2),
        .hit_o     (fwd_hit2),
        .data_o    (fwd_data2)
    );

endmodule
